// File: rtl/addsub_sequencer_if.sv
// Handshake bundle between requesters, the add/sub sequencer and the shared datapath.
// The slave view belongs to the sequencer; the master view belongs to requesters, the datapath and the response sink.
interface addsub_sequencer_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [WIDTH-1:0] req_a0;
   logic [WIDTH-1:0] req_b0;
   logic             req_sub0;
   logic [WIDTH-1:0] req_a1;
   logic [WIDTH-1:0] req_b1;
   logic             req_sub1;
   logic [WIDTH-1:0] dp_a;
   logic [WIDTH-1:0] dp_b;
   logic             dp_sub;
   logic [WIDTH-1:0] dp_ans;
   logic             dp_cout;
   logic             dp_v;
   logic             resp_valid;
   logic             resp_ready;
   logic             resp_id;
   logic [WIDTH-1:0] resp_ans;
   logic             resp_cout;
   logic             resp_v;
   logic             busy;
   logic [CNT_W-1:0] ovf_count;

   modport slave (
      input  req_valid, req_a0, req_b0, req_sub0, req_a1, req_b1, req_sub1,
      input  dp_ans, dp_cout, dp_v, resp_ready,
      output req_ready, dp_a, dp_b, dp_sub,
      output resp_valid, resp_id, resp_ans, resp_cout, resp_v, busy, ovf_count
   );

   modport master (
      output req_valid, req_a0, req_b0, req_sub0, req_a1, req_b1, req_sub1,
      output dp_ans, dp_cout, dp_v, resp_ready,
      input  req_ready, dp_a, dp_b, dp_sub,
      input  resp_valid, resp_id, resp_ans, resp_cout, resp_v, busy, ovf_count
   );
endinterface

// File: rtl/addsub_sequencer.sv
// Round-robin sequencer for the shared combinational add/sub datapath: grants one of two
// requesters, holds operands for SETTLE cycles, then returns the captured result tagged by id.
module addsub_sequencer #(
   parameter int WIDTH  = 32,
   parameter int SETTLE = 8,
   parameter int CNT_W  = 16
) (
   input logic               clk,
   input logic               rst_n,
   addsub_sequencer_if.slave seq_if
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   localparam logic [7:0] CNT_LOAD = 8'(SETTLE - 1);

   // Overflow statistics stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
      logic [CNT_W-1:0] res;
      if (&val) begin
         res = val;
      end else begin
         res = val + CNT_W'(1);
      end
      return res;
   endfunction

   state_t           state_q, state_d;
   logic             prio_q, prio_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             op_id_q, op_id_d;
   logic [WIDTH-1:0] dp_a_q, dp_a_d;
   logic [WIDTH-1:0] dp_b_q, dp_b_d;
   logic             dp_sub_q, dp_sub_d;
   logic             resp_valid_q, resp_valid_d;
   logic             resp_id_q, resp_id_d;
   logic [WIDTH-1:0] resp_ans_q, resp_ans_d;
   logic             resp_cout_q, resp_cout_d;
   logic             resp_v_q, resp_v_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] ovf_q, ovf_d;
   logic [1:0]       grant_s;
   logic             accept_s;

   // Grant decode: one requester at most, only while idle; prio breaks ties.
   always_comb begin
      grant_s = 2'b00;
      if (state_q == ST_IDLE) begin
         case (seq_if.req_valid)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = prio_q ? 2'b10 : 2'b01;
            default: grant_s = 2'b00;
         endcase
      end else begin
         grant_s = 2'b00;
      end
   end

   assign accept_s = |(seq_if.req_valid & grant_s);

   // Next-state and datapath/response register updates.
   always_comb begin
      state_d      = state_q;
      prio_d       = prio_q;
      cnt_d        = cnt_q;
      op_id_d      = op_id_q;
      dp_a_d       = dp_a_q;
      dp_b_d       = dp_b_q;
      dp_sub_d     = dp_sub_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_ans_d   = resp_ans_q;
      resp_cout_d  = resp_cout_q;
      resp_v_d     = resp_v_q;
      ovf_d        = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_WAIT;
               cnt_d   = CNT_LOAD;
               op_id_d = grant_s[1];
               if (grant_s[1]) begin
                  dp_a_d   = seq_if.req_a1;
                  dp_b_d   = seq_if.req_b1;
                  dp_sub_d = seq_if.req_sub1;
               end else begin
                  dp_a_d   = seq_if.req_a0;
                  dp_b_d   = seq_if.req_b0;
                  dp_sub_d = seq_if.req_sub0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // Operands have settled through the ripple chain once cnt reaches zero.
            if (cnt_q == 8'd0) begin
               state_d      = ST_RESP;
               resp_valid_d = 1'b1;
               resp_id_d    = op_id_q;
               resp_ans_d   = seq_if.dp_ans;
               resp_cout_d  = seq_if.dp_cout;
               resp_v_d     = seq_if.dp_v;
               if (seq_if.dp_v) begin
                  ovf_d = sat_inc(ovf_q);
               end else begin
                  ovf_d = ovf_q;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_RESP: begin
            if (resp_valid_q && seq_if.resp_ready) begin
               state_d      = ST_IDLE;
               resp_valid_d = 1'b0;
               prio_d       = ~resp_id_q;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         prio_q       <= 1'b0;
         cnt_q        <= 8'd0;
         op_id_q      <= 1'b0;
         dp_a_q       <= '0;
         dp_b_q       <= '0;
         dp_sub_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
         resp_ans_q   <= '0;
         resp_cout_q  <= 1'b0;
         resp_v_q     <= 1'b0;
         busy_q       <= 1'b0;
         ovf_q        <= '0;
      end else begin
         state_q      <= state_d;
         prio_q       <= prio_d;
         cnt_q        <= cnt_d;
         op_id_q      <= op_id_d;
         dp_a_q       <= dp_a_d;
         dp_b_q       <= dp_b_d;
         dp_sub_q     <= dp_sub_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_ans_q   <= resp_ans_d;
         resp_cout_q  <= resp_cout_d;
         resp_v_q     <= resp_v_d;
         busy_q       <= busy_d;
         ovf_q        <= ovf_d;
      end
   end

   assign seq_if.req_ready  = grant_s;
   assign seq_if.dp_a       = dp_a_q;
   assign seq_if.dp_b       = dp_b_q;
   assign seq_if.dp_sub     = dp_sub_q;
   assign seq_if.resp_valid = resp_valid_q;
   assign seq_if.resp_id    = resp_id_q;
   assign seq_if.resp_ans   = resp_ans_q;
   assign seq_if.resp_cout  = resp_cout_q;
   assign seq_if.resp_v     = resp_v_q;
   assign seq_if.busy       = busy_q;
   assign seq_if.ovf_count  = ovf_q;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Directed bench for addsub_sequencer: a default instance (SETTLE=8) plus a SETTLE=1, CNT_W=2
// instance for the saturation and single-cycle-wait cases.
module tb_addsub_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;

   addsub_sequencer_if #(.WIDTH(32), .CNT_W(16)) if1 ();
   addsub_sequencer_if #(.WIDTH(32), .CNT_W(2))  if2 ();

   addsub_sequencer #(.WIDTH(32), .SETTLE(8), .CNT_W(16)) dut1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .seq_if (if1.slave)
   );

   addsub_sequencer #(.WIDTH(32), .SETTLE(1), .CNT_W(2)) dut2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .seq_if (if2.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [33:0] dp_model(input logic [31:0] a, input logic [31:0] b, input logic sub);
      logic [31:0] bb;
      logic [32:0] sum;
      logic        v;
      bb  = sub ? ~b : b;
      sum = {1'b0, a} + {1'b0, bb} + {32'd0, sub};
      v   = (a[31] == bb[31]) && (sum[31] != a[31]);
      return {v, sum[32], sum[31:0]};
   endfunction

   // Behavioural stand-in for the combinational addsub32 datapath.
   always_comb begin
      {if1.dp_v, if1.dp_cout, if1.dp_ans} = dp_model(if1.dp_a, if1.dp_b, if1.dp_sub);
      {if2.dp_v, if2.dp_cout, if2.dp_ans} = dp_model(if2.dp_a, if2.dp_b, if2.dp_sub);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_resp1(output int n);
      n = 0;
      while (!if1.resp_valid && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_resp2(output int n);
      n = 0;
      while (!if2.resp_valid && n < 40) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int seen;
      int t_acc;
      int t_prev;
      logic [1:0] ovf_exp [5];
      ovf_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      if1.req_valid = 2'b00; if1.req_a0 = 32'd0; if1.req_b0 = 32'd0; if1.req_sub0 = 1'b0;
      if1.req_a1 = 32'd0; if1.req_b1 = 32'd0; if1.req_sub1 = 1'b0; if1.resp_ready = 1'b1;
      if2.req_valid = 2'b00; if2.req_a0 = 32'd0; if2.req_b0 = 32'd0; if2.req_sub0 = 1'b0;
      if2.req_a1 = 32'd0; if2.req_b1 = 32'd0; if2.req_sub1 = 1'b0; if2.resp_ready = 1'b1;

      // Reset state
      tick(); tick();
      check("rst_busy", 64'(if1.busy), 64'd0);
      check("rst_resp_valid", 64'(if1.resp_valid), 64'd0);
      check("rst_dp_a", 64'(if1.dp_a), 64'd0);
      check("rst_dp_sub", 64'(if1.dp_sub), 64'd0);
      check("rst_resp_ans", 64'(if1.resp_ans), 64'd0);
      check("rst_ovf", 64'(if1.ovf_count), 64'd0);
      check("rst_req_ready", 64'(if1.req_ready), 64'd0);
      rst_n = 1'b1;
      tick();

      // Simple add
      if1.req_a0 = 32'h0000_0021; if1.req_b0 = 32'h0000_0022; if1.req_sub0 = 1'b0;
      if1.req_valid = 2'b01;
      #1;
      check("add_ready", 64'(if1.req_ready), 64'h1);
      tick();
      if1.req_valid = 2'b00;
      check("add_busy", 64'(if1.busy), 64'd1);
      check("add_dp_a", 64'(if1.dp_a), 64'h21);
      wait_resp1(n);
      check("add_latency", 64'(n), 64'd8);
      check("add_ans", 64'(if1.resp_ans), 64'h43);
      check("add_cout", 64'(if1.resp_cout), 64'd0);
      check("add_v", 64'(if1.resp_v), 64'd0);
      check("add_id", 64'(if1.resp_id), 64'd0);
      tick();
      check("add_hs_valid", 64'(if1.resp_valid), 64'd0);
      check("add_hs_busy", 64'(if1.busy), 64'd0);
      check("add_ans_kept", 64'(if1.resp_ans), 64'h43);

      // Contention after reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      if1.req_a0 = 32'h7FFF_FFFF; if1.req_b0 = 32'h0000_0001; if1.req_sub0 = 1'b0;
      if1.req_a1 = 32'h336F_B7E5; if1.req_b1 = 32'h336F_B7E5; if1.req_sub1 = 1'b1;
      if1.req_valid = 2'b11;
      #1;
      check("cont_ready0", 64'(if1.req_ready), 64'h1);
      tick();
      if1.req_valid = 2'b10;
      wait_resp1(n);
      check("cont0_latency", 64'(n), 64'd8);
      check("cont0_ans", 64'(if1.resp_ans), 64'h8000_0000);
      check("cont0_v", 64'(if1.resp_v), 64'd1);
      check("cont0_cout", 64'(if1.resp_cout), 64'd0);
      check("cont0_id", 64'(if1.resp_id), 64'd0);
      check("cont0_ovf", 64'(if1.ovf_count), 64'd1);
      tick();
      check("cont_ready1", 64'(if1.req_ready), 64'h2);
      tick();
      if1.req_valid = 2'b00;
      check("cont1_dp_sub", 64'(if1.dp_sub), 64'd1);
      wait_resp1(n);
      check("cont1_ans", 64'(if1.resp_ans), 64'h0);
      check("cont1_cout", 64'(if1.resp_cout), 64'd1);
      check("cont1_v", 64'(if1.resp_v), 64'd0);
      check("cont1_id", 64'(if1.resp_id), 64'd1);
      check("cont1_ovf", 64'(if1.ovf_count), 64'd1);
      tick();

      // Alternation under continuous contention
      if1.req_a0 = 32'd1; if1.req_b0 = 32'd2; if1.req_sub0 = 1'b0;
      if1.req_a1 = 32'd5; if1.req_b1 = 32'd3; if1.req_sub1 = 1'b1;
      if1.req_valid = 2'b11;
      t_prev = 0;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("alt_grant", 64'(if1.req_ready), (k % 2 == 1) ? 64'h2 : 64'h1);
         tick();
         t_acc = cyc;
         if (k > 0) check("alt_interval", 64'(t_acc - t_prev), 64'd10);
         t_prev = t_acc;
         wait_resp1(n);
         check("alt_id", 64'(if1.resp_id), 64'(k % 2));
         check("alt_ans", 64'(if1.resp_ans), (k % 2 == 1) ? 64'd2 : 64'd3);
         tick();
      end
      if1.req_valid = 2'b00;

      // Backpressure
      if1.resp_ready = 1'b0;
      if1.req_a0 = 32'h8000_0000; if1.req_b0 = 32'h0000_0001; if1.req_sub0 = 1'b1;
      if1.req_valid = 2'b01;
      tick();
      if1.req_valid = 2'b00;
      wait_resp1(n);
      check("bp_latency", 64'(n), 64'd8);
      if1.req_valid = 2'b11;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("bp_valid", 64'(if1.resp_valid), 64'd1);
         check("bp_ans", 64'(if1.resp_ans), 64'h7FFF_FFFF);
         check("bp_v", 64'(if1.resp_v), 64'd1);
         check("bp_req_ready", 64'(if1.req_ready), 64'h0);
         check("bp_dp_a", 64'(if1.dp_a), 64'h8000_0000);
         check("bp_dp_b", 64'(if1.dp_b), 64'h1);
         check("bp_dp_sub", 64'(if1.dp_sub), 64'd1);
         tick();
      end
      if1.req_valid = 2'b00;
      if1.resp_ready = 1'b1;
      tick();
      check("bp_hs", 64'(if1.resp_valid), 64'd0);
      check("bp_ovf", 64'(if1.ovf_count), 64'd2);

      // Reset mid-WAIT
      if1.req_a1 = 32'h7FFF_FFFF; if1.req_b1 = 32'h0000_0001; if1.req_sub1 = 1'b0;
      if1.req_valid = 2'b10;
      tick();
      if1.req_valid = 2'b00;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      check("rstw_busy", 64'(if1.busy), 64'd0);
      check("rstw_ovf", 64'(if1.ovf_count), 64'd0);
      check("rstw_dp_a", 64'(if1.dp_a), 64'd0);
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (if1.resp_valid) seen++;
      end
      check("rstw_no_resp", 64'(seen), 64'd0);
      if1.req_a0 = 32'h0000_0100; if1.req_b0 = 32'h0000_00FF; if1.req_sub0 = 1'b0;
      if1.req_valid = 2'b01;
      #1;
      check("rstw_ready", 64'(if1.req_ready), 64'h1);
      tick();
      if1.req_valid = 2'b00;
      wait_resp1(n);
      check("rstw_latency", 64'(n), 64'd8);
      check("rstw_ans", 64'(if1.resp_ans), 64'h1FF);
      check("rstw_id", 64'(if1.resp_id), 64'd0);
      tick();

      // Saturation with CNT_W=2, SETTLE=1
      if2.req_a0 = 32'h784E_BA56; if2.req_b0 = 32'h7B51_40F2; if2.req_sub0 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if2.req_valid = 2'b01;
         tick();
         if2.req_valid = 2'b00;
         wait_resp2(n);
         check("sat_latency", 64'(n), 64'd1);
         check("sat_ans", 64'(if2.resp_ans), 64'hF39F_FB48);
         check("sat_v", 64'(if2.resp_v), 64'd1);
         check("sat_ovf", 64'(if2.ovf_count), 64'(ovf_exp[k]));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
